// File: rtl/rf_pkg.sv
// Shared defaults and packed-bus lane helpers for the multi-port register file.
package rf_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned ZERO_ADDR  = 0;

   // LSB position of lane 'lane' in a packed bus of 'width'-bit lanes.
   function automatic int unsigned laneLsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy vector plus an incrementally maintained busy count.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   output logic [(1<<ADDR_W)-1:0]   busy,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

   logic             setOk;
   logic             setNew;
   logic             clr0;
   logic             clr1;
   logic [DEPTH-1:0] setMask;
   logic [DEPTH-1:0] clrMask;

   // A set on the same address as a clear wins; a shared clear address counts once.
   always_comb begin
      setOk   = set_en && !(ZERO_REG && (set_addr == ZERO_A));
      setMask = '0;
      clrMask = '0;
      if (setOk)  setMask[set_addr] = 1'b1;
      if (wr0_en) clrMask[wr0_addr] = 1'b1;
      if (wr1_en) clrMask[wr1_addr] = 1'b1;
      setNew = setOk && !busy[set_addr];
      clr0   = wr0_en && busy[wr0_addr] && !(setOk && (set_addr == wr0_addr));
      clr1   = wr1_en && busy[wr1_addr] && !(setOk && (set_addr == wr1_addr))
               && !(wr0_en && (wr0_addr == wr1_addr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= (busy & ~clrMask) | setMask;
         busy_cnt <= busy_cnt + CNT_W'(setNew) - CNT_W'(clr0) - CNT_W'(clr1);
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read, dual-write register file with bypass, zero register
// and a pending-write scoreboard.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr0Ok;
   logic              wr1Ok;

   assign wr0Ok = wr0_en && !(ZERO_REG && (wr0_addr == ZERO_A));
   assign wr1Ok = wr1_en && !(ZERO_REG && (wr1_addr == ZERO_A));

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (wr0Ok) regs[wr0_addr] <= wr0_data;
         if (wr1Ok) regs[wr1_addr] <= wr1_data;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) uScoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (set_en),
      .set_addr (set_addr),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : gRead
      logic [ADDR_W-1:0] portAddr;
      logic [DATA_W-1:0] portData;
      logic              portBusy;

      assign portAddr = rd_addr[laneLsb(i, ADDR_W) +: ADDR_W];

      // Later checks override earlier ones, giving zero > wr1 > wr0 > stored.
      always_comb begin
         portData = regs[portAddr];
         portBusy = busy[portAddr];
         if (BYPASS && wr0_en && (wr0_addr == portAddr)) begin
            portData = wr0_data;
            portBusy = 1'b0;
         end
         if (BYPASS && wr1_en && (wr1_addr == portAddr)) begin
            portData = wr1_data;
            portBusy = 1'b0;
         end
         if ((ZERO_REG && (portAddr == ZERO_A)) || rst) begin
            portData = '0;
            portBusy = 1'b0;
         end
      end

      assign rd_data[laneLsb(i, DATA_W) +: DATA_W] = portData;
      assign rd_busy[i] = portBusy;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table, busy-count queue and reset/bypass sequences.
module tb_reg_file_mp;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR*AW-1:0] rdAddr;
   logic [NR*DW-1:0] rdDataA, rdDataB;
   logic [NR-1:0]    rdBusyA, rdBusyB;
   logic            wr0En, wr1En, setEn;
   logic [AW-1:0]   wr0Addr, wr1Addr, setAddr;
   logic [DW-1:0]   wr0Data, wr1Data;
   logic [AW:0]     cntA, cntB;

   int checks = 0;
   int errors = 0;
   logic [AW:0] expQ [$];

   typedef struct {
      logic          w0e;
      logic [AW-1:0] w0a;
      logic [DW-1:0] w0d;
      logic          w1e;
      logic [AW-1:0] w1a;
      logic [DW-1:0] w1d;
      logic          se;
      logic [AW-1:0] sa;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] expRd0;
      logic          expBusy0;
      logic [DW-1:0] expRd1;
      logic [AW:0]   expCnt;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   reg_file_mp #(.BYPASS(1'b1)) dutA (
      .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
      .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
      .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
      .set_en(setEn), .set_addr(setAddr), .busy_cnt(cntA)
   );

   reg_file_mp #(.BYPASS(1'b0)) dutB (
      .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
      .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
      .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
      .set_en(setEn), .set_addr(setAddr), .busy_cnt(cntB)
   );

   function automatic vec_t mk(input int w0e, input int w0a, input int w0d,
                               input int w1e, input int w1a, input int w1d,
                               input int se, input int sa, input int ra0, input int ra1,
                               input int eRd0, input int eB0, input int eRd1, input int eCnt);
      vec_t v;
      v.w0e = 1'(w0e);  v.w0a = AW'(w0a);  v.w0d = DW'(w0d);
      v.w1e = 1'(w1e);  v.w1a = AW'(w1a);  v.w1d = DW'(w1d);
      v.se  = 1'(se);   v.sa  = AW'(sa);
      v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
      v.expRd0 = DW'(eRd0); v.expBusy0 = 1'(eB0); v.expRd1 = DW'(eRd1); v.expCnt = (AW+1)'(eCnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int w0e, input int w0a, input int w0d,
                        input int w1e, input int w1a, input int w1d,
                        input int se, input int sa, input int ra0, input int ra1);
      @(negedge clk);
      wr0En = 1'(w0e); wr0Addr = AW'(w0a); wr0Data = DW'(w0d);
      wr1En = 1'(w1e); wr1Addr = AW'(w1a); wr1Data = DW'(w1d);
      setEn = 1'(se);  setAddr = AW'(sa);
      rdAddr = {AW'(ra1), AW'(ra0)};
      #1;
   endtask

   // Pop the expected count pushed when this cycle's stimulus was driven.
   task automatic closeCycle();
      logic [AW:0] e;
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         chk("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = expQ.pop_front();
         chk("busy_cnt_A", 32'(cntA), 32'(e));
         chk("busy_cnt_B", 32'(cntB), 32'(e));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(0,0,0,          0,0,0,          1,4, 4,0, 0,0,0, 1);
      vecs[1]  = mk(0,0,0,          0,0,0,          0,0, 4,0, 0,1,0, 1);
      vecs[2]  = mk(1,4,'h1111,     0,0,0,          0,0, 4,0, 'h1111,0,0, 0);
      vecs[3]  = mk(0,0,0,          0,0,0,          0,0, 4,7, 'h1111,0,0, 0);
      vecs[4]  = mk(1,7,'hAAAA,     1,7,'h5555,     0,0, 7,4, 'h5555,0,'h1111, 0);
      vecs[5]  = mk(0,0,0,          0,0,0,          0,0, 7,0, 'h5555,0,0, 0);
      vecs[6]  = mk(0,0,0,          0,0,0,          1,9, 9,0, 0,0,0, 1);
      vecs[7]  = mk(0,0,0,          1,9,'h99,       1,9, 9,0, 'h99,0,0, 1);
      vecs[8]  = mk(0,0,0,          0,0,0,          0,0, 9,0, 'h99,1,0, 1);
      vecs[9]  = mk(0,0,0,          1,0,'h1234,     1,0, 0,0, 0,0,0, 1);
      vecs[10] = mk(0,0,0,          0,0,0,          0,0, 0,9, 0,0,'h99, 1);
      vecs[11] = mk(1,9,'h5,        0,0,0,          0,0, 9,0, 'h5,0,0, 0);
      vecs[12] = mk(0,0,0,          1,3,'h33,       0,0, 3,0, 'h33,0,0, 0);

      rst = 1'b1;
      wr0En = 1'b0; wr0Addr = '0; wr0Data = '0;
      wr1En = 1'b0; wr1Addr = '0; wr1Data = '0;
      setEn = 1'b0; setAddr = '0; rdAddr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cnt", 32'(cntA), 32'd0);
      chk("reset_rd", rdDataA[31:0], 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Write with bypass off shows the old value until the edge.
      drive(1,3,'h77, 0,0,0, 0,0, 3,0);
      chk("nobyp_same_cycle", rdDataB[31:0], 32'h0);
      chk("byp_same_cycle", rdDataA[31:0], 32'h77);
      expQ.push_back('0);
      closeCycle();
      drive(0,0,0, 0,0,0, 0,0, 3,0);
      chk("nobyp_next_cycle", rdDataB[31:0], 32'h77);
      expQ.push_back('0);
      closeCycle();

      for (int i = 0; i < 13; i++) begin
         drive(int'(vecs[i].w0e), int'(vecs[i].w0a), int'(vecs[i].w0d),
               int'(vecs[i].w1e), int'(vecs[i].w1a), int'(vecs[i].w1d),
               int'(vecs[i].se), int'(vecs[i].sa), int'(vecs[i].ra0), int'(vecs[i].ra1));
         chk($sformatf("vec%0d_rd0", i), rdDataA[31:0], vecs[i].expRd0);
         chk($sformatf("vec%0d_busy0", i), 32'(rdBusyA[0]), 32'(vecs[i].expBusy0));
         chk($sformatf("vec%0d_rd1", i), rdDataA[63:32], vecs[i].expRd1);
         expQ.push_back(vecs[i].expCnt);
         closeCycle();
      end

      // Fill the scoreboard, then a shared two-port clear counts once.
      for (int r = 1; r < 32; r++) begin
         drive(0,0,0, 0,0,0, 1,r, r,0);
         expQ.push_back((AW+1)'(r));
         closeCycle();
      end
      drive(1,2,'h22, 1,2,'h2222, 0,0, 2,0);
      chk("dual_clear_rd", rdDataA[31:0], 32'h2222);
      chk("dual_clear_busy", 32'(rdBusyA[0]), 32'd0);
      expQ.push_back((AW+1)'(30));
      closeCycle();
      drive(0,0,0, 0,0,0, 1,0, 0,0);
      chk("zero_busy", 32'(rdBusyA[0]), 32'd0);
      expQ.push_back((AW+1)'(30));
      closeCycle();
      drive(1,5,'hDEADBEEF, 0,0,0, 0,0, 5,6);
      expQ.push_back((AW+1)'(29));
      closeCycle();
      drive(0,0,0, 0,0,0, 0,0, 5,6);
      chk("r5_stored", rdDataA[31:0], 32'hDEADBEEF);
      chk("r6_busy", 32'(rdBusyA[1]), 32'd1);
      expQ.push_back((AW+1)'(29));
      closeCycle();

      // Asynchronous reset mid-cycle, observed before any clock edge.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rd", rdDataA[31:0], 32'h0);
      chk("async_rst_busy", 32'(rdBusyA[1]), 32'd0);
      chk("async_rst_cnt", 32'(cntA), 32'd0);
      drive(1,6,'h66, 0,0,0, 1,7, 5,6);
      chk("rst_rd_bypass", rdDataA[63:32], 32'h0);
      @(posedge clk);
      #1;
      chk("rst_set_ignored", 32'(cntA), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wr0En = 1'b0;
      setEn = 1'b0;
      #1;
      chk("rst_wr_ignored", rdDataA[63:32], 32'h0);

      drive(0,0,0, 1,0,'h1234, 0,0, 0,0);
      chk("r0_write_same", rdDataA[31:0], 32'h0);
      expQ.push_back('0);
      closeCycle();
      drive(0,0,0, 0,0,0, 0,0, 0,0);
      chk("r0_write_after", rdDataA[31:0], 32'h0);
      expQ.push_back('0);
      closeCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the 32x32 two-read/one-write register pile.
- Configurable data width, depth and read-port count; two write ports with fixed priority; optional write-to-read bypass; optional hardwired zero register.
- Adds asynchronous clear and a per-register pending-write scoreboard with a live busy count.
- Sits in the decode stage: issue logic marks destinations busy, and the two writeback lanes (ALU, load) write data back and clear busy.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle writes forward to reads and suppress busy; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port busy flag for the addressed register, combinational.
- wr0_en  in  1  write port 0 enable (ALU lane).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load lane; higher priority).
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- set_en  in  1  mark a register pending (instruction issued).
- set_addr  in  ADDR_W  register to mark pending.
- busy_cnt  out  ADDR_W+1  number of currently busy registers, registered.

Behaviour:
- Reset: clk and rst only, asynchronous active-high. On rst assertion, all registers go to 0, all busy bits to 0 and busy_cnt to 0, immediately and independent of clk. While rst is high, rd_data reads 0 and rd_busy reads 0. Writes and sets are ignored during rst. Normal operation resumes at the first rising clk edge after rst deasserts.
- Write: on posedge, if wrN_en, then reg[wrN_addr] <= wrN_data. If both ports are enabled at the same address, port 1's data is stored.
- Zero register (ZERO_REG=1): address 0 ignores writes and sets; reads return 0; rd_busy is 0. With ZERO_REG=0, register 0 is ordinary.
- Read, per port i, evaluated in priority order:
  1. ZERO_REG and addr==0 -> 0.
  2. BYPASS, wr1_en and wr1_addr==addr -> wr1_data.
  3. BYPASS, wr0_en and wr0_addr==addr -> wr0_data.
  4. Otherwise -> stored value.
  With BYPASS=0, the new value appears on the cycle after the write edge.
- Scoreboard, updated on posedge:
  - A write on either port clears busy[wr_addr].
  - set_en sets busy[set_addr].
  - If a set and a clear target the same address in the same cycle, the set wins (a new producer supersedes the old one) and busy stays 1.
- rd_busy[i] = busy[addr_i], forced to 0 when BYPASS=1 and addr_i matches an enabled write this cycle. Forced to 0 for the zero register.
- busy_cnt is registered and tracks the number of 1 bits in the busy vector exactly:
  - Net delta per cycle = +1 if set_en targets a non-busy, valid address.
  - Minus the number of distinct busy addresses cleared and not re-set that cycle.
  - Two write ports hitting the same busy address count as one clear.
  - The count is in the range 0..DEPTH; it never wraps or underflows.
- Clearing a register that is not busy is legal and has no effect on busy or busy_cnt.
- Reads have no side effects. Read/write collisions are deterministic as listed above.

Decomposition:
- Shared package rf_pkg holds:
  - Defaults for DATA_W and ADDR_W.
  - The pack/unpack helper functions for the packed read buses.
  - The constant ZERO_ADDR.
- Natural sub-module: rf_scoreboard. It owns the busy vector, the set/clear priority logic and busy_cnt. Its inputs are set_en/set_addr and both write enables/addresses. Its outputs are the busy vector and busy_cnt.
- The top level keeps the storage array, the write logic and the read/bypass muxes.

Test Plan:
1. Reset and zero register: assert rst mid-run after writing 0xDEADBEEF to r5 -> rd_data reads 0 for r5 immediately (before any clk edge) and busy_cnt=0. Then write 0x1234 to r0 -> r0 still reads 0.
2. Dual-write collision: wr0 writes 0xAAAA to r7 and wr1 writes 0x5555 to r7 in the same cycle -> the same-cycle read of r7 returns 0x5555 (BYPASS=1). The next cycle it still reads 0x5555.
3. BYPASS=0 build: write 0x77 to r3 -> the same-cycle read returns the old value 0; the cycle after returns 0x77.
4. Scoreboard: set r4 -> next cycle rd_busy=1 and busy_cnt=1. Then wr0 writes r4 -> the same-cycle rd_busy=0 (bypass). After the edge, busy_cnt=0.
5. Set/clear race: r9 busy, then set_en r9 and wr1 r9 in the same cycle -> busy[r9] stays 1 and busy_cnt is unchanged.
6. Count accuracy: set r1..r31 on consecutive cycles -> busy_cnt=31. Then both write ports clear r2 in the same cycle -> busy_cnt=30 (decrements by 1, not 2).
